// File: rtl/conv_job_scheduler.sv
// Job queue and sequencer for the conv2d engine: per queued job it clears the engine,
// starts it, rebases its addresses onto the shared memory port and reports completion.
module conv_job_scheduler #(
   parameter int AddressBitWidth = 17,
   parameter int JobIdWidth      = 4,
   parameter int QueueAddrWidth  = 2,
   parameter int QueueDepth      = 4,
   parameter int TimeoutBitWidth = 16,
   parameter int TimeoutCycles   = 4000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       job_valid,
   output logic                       job_ready,
   input  logic [JobIdWidth-1:0]      job_id,
   input  logic [AddressBitWidth-1:0] job_rd_base,
   input  logic [AddressBitWidth-1:0] job_wr_base,
   output logic                       eng_rst,
   output logic                       eng_start,
   input  logic                       eng_ready,
   input  logic [AddressBitWidth-1:0] eng_rd_addr,
   input  logic [AddressBitWidth-1:0] eng_wr_addr,
   input  logic                       eng_we,
   output logic [AddressBitWidth-1:0] mem_rd_addr,
   output logic [AddressBitWidth-1:0] mem_wr_addr,
   output logic                       mem_we,
   output logic                       done_valid,
   output logic [JobIdWidth-1:0]      done_id,
   output logic                       done_timeout,
   input  logic                       done_ack,
   output logic                       busy
);

   typedef enum logic [2:0] {IDLE, CLEAR, START, RUN, REPORT} state_t;

   localparam logic [TimeoutBitWidth-1:0] WdLast   = TimeoutBitWidth'(TimeoutCycles - 1);
   localparam logic [TimeoutBitWidth-1:0] WdOne    = TimeoutBitWidth'(1);
   localparam logic [QueueAddrWidth:0]    CountMax = (QueueAddrWidth + 1)'(QueueDepth);
   localparam logic [QueueAddrWidth:0]    CountOne = (QueueAddrWidth + 1)'(1);
   localparam logic [QueueAddrWidth-1:0]  PtrLast  = QueueAddrWidth'(QueueDepth - 1);
   localparam logic [QueueAddrWidth-1:0]  PtrOne   = QueueAddrWidth'(1);

   state_t                      state_q, state_d;
   logic [JobIdWidth-1:0]       q_id_q [QueueDepth];
   logic [AddressBitWidth-1:0]  q_rd_q [QueueDepth];
   logic [AddressBitWidth-1:0]  q_wr_q [QueueDepth];
   logic [QueueAddrWidth-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [QueueAddrWidth:0]     count_q, count_d;
   logic [TimeoutBitWidth-1:0]  wd_q, wd_d;
   logic                        eng_start_q, eng_start_d;
   logic                        done_valid_q, done_valid_d;
   logic                        done_timeout_q, done_timeout_d;
   logic [JobIdWidth-1:0]       done_id_q, done_id_d;
   logic                        push, pop, empty;

   function automatic logic [QueueAddrWidth-1:0] ptr_inc(input logic [QueueAddrWidth-1:0] p);
      return (p == PtrLast) ? '0 : p + PtrOne;
   endfunction

   assign empty       = (count_q == '0);
   assign job_ready   = (count_q != CountMax);
   assign push        = job_valid & job_ready;
   assign pop         = (state_q == REPORT) & done_ack;

   // Engine addresses are relative to the head job; the carry out is intentionally dropped.
   assign mem_rd_addr = q_rd_q[rd_ptr_q] + eng_rd_addr;
   assign mem_wr_addr = q_wr_q[rd_ptr_q] + eng_wr_addr;
   assign mem_we      = eng_we & (state_q == RUN);
   assign eng_rst     = rst | (state_q == CLEAR);
   assign eng_start   = eng_start_q;
   assign done_valid  = done_valid_q;
   assign done_id     = done_id_q;
   assign done_timeout = done_timeout_q;
   assign busy        = (state_q != IDLE) | ~empty;

   always_comb begin
      state_d        = state_q;
      wd_d           = wd_q;
      done_valid_d   = done_valid_q;
      done_id_d      = done_id_q;
      done_timeout_d = done_timeout_q;
      unique case (state_q)
         IDLE:   if (!empty) state_d = CLEAR;
         CLEAR:  state_d = START;
         START: begin
            state_d = RUN;
            wd_d    = '0;
         end
         RUN: begin
            // A ready seen on the final watchdog cycle still counts as a clean finish.
            if (eng_ready) begin
               state_d        = REPORT;
               done_valid_d   = 1'b1;
               done_id_d      = q_id_q[rd_ptr_q];
               done_timeout_d = 1'b0;
            end else if (wd_q == WdLast) begin
               state_d        = REPORT;
               done_valid_d   = 1'b1;
               done_id_d      = q_id_q[rd_ptr_q];
               done_timeout_d = 1'b1;
            end else begin
               wd_d = wd_q + WdOne;
            end
         end
         REPORT: begin
            if (done_ack) begin
               state_d      = IDLE;
               done_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      eng_start_d = (state_d == START);
   end

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CountOne;
         2'b01:   count_d = count_q - CountOne;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         wd_q           <= '0;
         eng_start_q    <= 1'b0;
         done_valid_q   <= 1'b0;
         done_id_q      <= '0;
         done_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         wd_q           <= wd_d;
         eng_start_q    <= eng_start_d;
         done_valid_q   <= done_valid_d;
         done_id_q      <= done_id_d;
         done_timeout_q <= done_timeout_d;
      end
   end

   // Queue payload storage carries no reset; the pointers alone define its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         q_id_q[wr_ptr_q] <= job_id;
         q_rd_q[wr_ptr_q] <= job_rd_base;
         q_wr_q[wr_ptr_q] <= job_wr_base;
      end
   end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Bench for conv_job_scheduler: a behavioural engine drives the main instance and
// scoreboards track completions and memory writes; a second instance exercises the watchdog.
module tb_conv_job_scheduler;
   localparam int AW = 17;
   localparam int IW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          job_valid, job_ready;
   logic [IW-1:0] job_id;
   logic [AW-1:0] job_rd_base, job_wr_base;
   logic          eng_rst, eng_start, eng_ready, eng_we;
   logic [AW-1:0] eng_rd_addr, eng_wr_addr, mem_rd_addr, mem_wr_addr;
   logic          mem_we, done_valid, done_timeout, done_ack, busy;
   logic [IW-1:0] done_id;

   logic          job_valid_w, job_ready_w;
   logic [IW-1:0] job_id_w;
   logic [AW-1:0] job_rd_base_w, job_wr_base_w;
   logic          eng_rst_w, eng_start_w, eng_ready_w, eng_we_w;
   logic [AW-1:0] eng_rd_addr_w, eng_wr_addr_w, mem_rd_addr_w, mem_wr_addr_w;
   logic          mem_we_w, done_valid_w, done_timeout_w, done_ack_w, busy_w;
   logic [IW-1:0] done_id_w;

   conv_job_scheduler dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
      .job_rd_base(job_rd_base), .job_wr_base(job_wr_base), .eng_rst(eng_rst),
      .eng_start(eng_start), .eng_ready(eng_ready), .eng_rd_addr(eng_rd_addr),
      .eng_wr_addr(eng_wr_addr), .eng_we(eng_we), .mem_rd_addr(mem_rd_addr),
      .mem_wr_addr(mem_wr_addr), .mem_we(mem_we), .done_valid(done_valid), .done_id(done_id),
      .done_timeout(done_timeout), .done_ack(done_ack), .busy(busy)
   );

   conv_job_scheduler #(.TimeoutCycles(16)) dut_wd (
      .clk(clk), .rst(rst), .job_valid(job_valid_w), .job_ready(job_ready_w), .job_id(job_id_w),
      .job_rd_base(job_rd_base_w), .job_wr_base(job_wr_base_w), .eng_rst(eng_rst_w),
      .eng_start(eng_start_w), .eng_ready(eng_ready_w), .eng_rd_addr(eng_rd_addr_w),
      .eng_wr_addr(eng_wr_addr_w), .eng_we(eng_we_w), .mem_rd_addr(mem_rd_addr_w),
      .mem_wr_addr(mem_wr_addr_w), .mem_we(mem_we_w), .done_valid(done_valid_w),
      .done_id(done_id_w), .done_timeout(done_timeout_w), .done_ack(done_ack_w), .busy(busy_w)
   );

   typedef struct { logic [IW-1:0] id; logic to; } done_t;
   typedef struct { logic [AW-1:0] rd; logic [AW-1:0] wr; } wr_t;

   done_t exp_done[$];
   wr_t   exp_wr[$];
   int    len_q[$];
   int    pop_cyc[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    n_start = 0, n_clr = 0, start_cyc = 0;
   logic [AW-1:0] last_rd = '0;
   bit    hold_ack = 1'b0, stray_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Behavioural engine: one write per RUN cycle, last write coincides with sticky ready.
   initial begin
      int k, cur_len;
      bit running, go;
      eng_ready = 1'b0; eng_we = 1'b0; eng_rd_addr = '0; eng_wr_addr = '0;
      running = 1'b0; go = 1'b0; k = 0; cur_len = 1;
      forever begin
         @(posedge clk); #1;
         if (eng_rst) begin
            eng_ready = 1'b0; eng_we = 1'b0; running = 1'b0; go = 1'b0;
         end else begin
            if (go) begin
               cur_len = (len_q.size() > 0) ? len_q.pop_front() : 1;
               running = 1'b1; k = 0; eng_rd_addr = '0; eng_wr_addr = '0; eng_we = 1'b1;
               eng_ready = (cur_len == 1);
            end else if (running) begin
               if (eng_ready) begin
                  running = 1'b0; eng_we = 1'b0;
               end else begin
                  k++;
                  eng_rd_addr = AW'(k); eng_wr_addr = AW'(k);
                  eng_ready = (k == cur_len - 1);
               end
            end else if (stray_en) begin
               eng_we = ~eng_we;
            end
            go = eng_start;
         end
      end
   end

   initial begin
      done_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         done_ack = done_valid & ~hold_ack;
      end
   end

   // Completion monitor
   initial begin
      done_t e;
      forever begin
         @(negedge clk);
         if (!rst && done_valid && done_ack) begin
            if (exp_done.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected: got id %0d, expected no completion", done_id);
            end else begin
               e = exp_done.pop_front();
               chk("done_id", done_id, e.id);
               chk("done_timeout", done_timeout, e.to);
               pop_cyc.push_back(cyc);
            end
         end
      end
   end

   // Memory write monitor
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         if (mem_we) begin
            if (exp_wr.size() == 0) begin
               checks++; errors++;
               $display("FAIL mem_we_unexpected: got write to %0d, expected none", mem_wr_addr);
            end else begin
               w = exp_wr.pop_front();
               chk("mem_wr_addr", mem_wr_addr, w.wr);
               chk("mem_rd_addr", mem_rd_addr, w.rd);
            end
            last_rd = mem_rd_addr;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (eng_start) begin n_start++; start_cyc = cyc; end
         if (eng_rst && !rst) n_clr++;
      end
   end

   task automatic push_job(input int id, input int rd, input int wr, input int len, output int acc);
      done_t d;
      wr_t   w;
      job_id = IW'(id); job_rd_base = AW'(rd); job_wr_base = AW'(wr); job_valid = 1'b1;
      acc = -1;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (job_ready) begin acc = cyc; break; end
      end
      if (acc < 0) begin
         checks++; errors++;
         $display("FAIL push_timeout: job %0d not accepted, expected acceptance", id);
      end else begin
         d.id = IW'(id); d.to = 1'b0;
         exp_done.push_back(d);
         for (int k = 0; k < len; k++) begin
            w.rd = AW'(rd + k); w.wr = AW'(wr + k);
            exp_wr.push_back(w);
         end
         len_q.push_back(len);
      end
      @(posedge clk); #1;
      job_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int pending;
      pending = 1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         pending = (busy || exp_done.size() != 0 || exp_wr.size() != 0) ? 1 : 0;
         if (pending == 0) break;
      end
      chk({nm, "_drained"}, pending, 0);
      @(posedge clk); #1;
   endtask

   task automatic push_w(input int id);
      int ok;
      job_id_w = IW'(id); job_valid_w = 1'b1; ok = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (job_ready_w) begin ok = 1; break; end
      end
      chk("wd_push_accepted", ok, 1);
      @(posedge clk); #1;
      job_valid_w = 1'b0;
   endtask

   initial begin
      int acc, acc5, s0, c0, cnt;
      rst = 1'b1; job_valid = 1'b0; job_id = '0; job_rd_base = '0; job_wr_base = '0;
      job_valid_w = 1'b0; job_id_w = '0; job_rd_base_w = '0; job_wr_base_w = '0;
      eng_ready_w = 1'b0; eng_we_w = 1'b1; eng_rd_addr_w = '0; eng_wr_addr_w = '0;
      done_ack_w = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_job_ready", job_ready, 1);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_eng_rst", eng_rst, 1);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_done_timeout", done_timeout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_we_w", mem_we_w, 0);
      chk("rst_busy_w", busy_w, 0);
      @(posedge clk); #1;
      rst = 1'b0; eng_we_w = 1'b0;

      // Single 5x5 job
      s0 = n_start; c0 = n_clr;
      push_job(3, 100, 500, 25, acc);
      wait_idle("t1");
      chk("t1_start_pulses", n_start - s0, 1);
      chk("t1_clear_pulses", n_clr - c0, 1);
      chk("t1_push_to_start", start_cyc - acc, 3);

      // Fill the queue, fifth job held off until the first pop
      s0 = n_start; c0 = n_clr; pop_cyc.delete();
      for (int i = 0; i < 4; i++) push_job(i, 1000 + i * 64, 2000 + i * 64, 3, acc);
      @(negedge clk);
      chk("t2_ready_when_full", job_ready, 0);
      @(posedge clk); #1;
      push_job(4, 1300, 2300, 3, acc5);
      wait_idle("t2");
      chk("t2_fifth_after_pop", acc5, (pop_cyc.size() > 0) ? pop_cyc[0] + 1 : -1);
      chk("t2_start_pulses", n_start - s0, 5);
      chk("t2_clear_pulses", n_clr - c0, 5);

      // Completion held without ack while the engine toggles stray writes
      hold_ack = 1'b1; stray_en = 1'b1;
      push_job(9, 40, 3000, 4, acc);
      push_job(10, 80, 3100, 4, acc);
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (done_valid) break;
      end
      for (int i = 0; i < 10; i++) begin
         chk("t4_valid_held", done_valid, 1);
         chk("t4_id_held", done_id, 9);
         chk("t4_no_start", eng_start, 0);
         chk("t4_mem_we_blocked", mem_we, 0);
         @(negedge clk);
      end
      hold_ack = 1'b0;
      wait_idle("t4");
      stray_en = 1'b0;

      // Read address wraps modulo 2**17
      push_job(5, 131070, 10, 6, acc);
      wait_idle("t5");
      chk("t5_rd_wrap", last_rd, 3);

      // Reset in the middle of a running job
      push_job(6, 200, 700, 50, acc);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (eng_start) break;
      end
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("t6_eng_rst_in_rst", eng_rst, 1);
      @(posedge clk); #2;
      exp_wr.delete(); exp_done.delete(); len_q.delete();
      repeat (2) begin
         @(negedge clk);
         chk("t6_eng_rst_in_rst", eng_rst, 1);
         chk("t6_job_ready", job_ready, 1);
         chk("t6_busy", busy, 0);
         chk("t6_done_valid", done_valid, 0);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_eng_rst_released", eng_rst, 0);
      chk("t6_queue_empty", busy, 0);
      @(posedge clk); #1;
      push_job(11, 300, 900, 5, acc);
      wait_idle("t6_after");

      // Watchdog instance: timeout, then ready on the final watchdog cycle
      push_w(7);
      push_w(8);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (eng_start_w) break;
      end
      chk("wd_start1", eng_start_w, 1);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!done_valid_w && cnt < 100);
      chk("wd_timeout_latency", cnt, 17);
      chk("wd_timeout_id", done_id_w, 7);
      chk("wd_timeout_flag", done_timeout_w, 1);
      @(posedge clk); #1 done_ack_w = 1'b1;
      @(posedge clk); #1 done_ack_w = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (eng_rst_w) break;
      end
      chk("wd_clear2", eng_rst_w, 1);
      chk("wd_valid_cleared", done_valid_w, 0);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (eng_start_w) break;
      end
      chk("wd_start2", eng_start_w, 1);
      repeat (16) @(posedge clk);
      #1 eng_ready_w = 1'b1;
      @(negedge clk);
      chk("wd_still_running", done_valid_w, 0);
      @(negedge clk);
      chk("wd_ready_wins_valid", done_valid_w, 1);
      chk("wd_ready_wins_flag", done_timeout_w, 0);
      chk("wd_ready_wins_id", done_id_w, 8);
      @(posedge clk); #1 done_ack_w = 1'b1;
      @(posedge clk); #1 done_ack_w = 1'b0; eng_ready_w = 1'b0;
      repeat (2) @(negedge clk);
      chk("wd_idle", busy_w, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL global_timeout: simulation did not complete, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
